// File: rtl/seq_mult_unit.sv
// Sequential 8x8 shift-and-add multiplier feeding a register-file write port.
// One multiplier bit is consumed per cycle, so latency is fixed regardless of
// operand values. The write-back outputs are registered on the WB edge, which
// places the WRITE pulse in the cycle after WB.
module seq_mult_unit #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] OP1,
  input  logic [DATA_W-1:0] OP2,
  input  logic [2:0]        DESTADDR,
  output logic [DATA_W-1:0] RESULT,
  output logic [2:0]        WRITEADDR,
  output logic              WRITE,
  output logic              BUSY,
  output logic              OVF
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [2:0]        dest;

  // Control FSM, operand latches, accumulator and registered write-back outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      dest      <= '0;
      RESULT    <= '0;
      WRITEADDR <= '0;
      OVF       <= 1'b0;
      WRITE     <= 1'b0;
    end else begin
      WRITE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            mcand  <= OP1;
            mplier <= OP2;
            dest   <= DESTADDR;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[cnt[IDX_W-1:0]]) begin
            acc <= acc + (ACC_W'(mcand) << cnt);
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= WB;
          end
        end
        WB: begin
          RESULT    <= acc[DATA_W-1:0];
          OVF       <= |acc[ACC_W-1:DATA_W];
          WRITEADDR <= dest;
          WRITE     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall indication decoded from the state register only
  always_comb begin
    BUSY = (state == RUN) || (state == WB);
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: vector table plus reset/abort,
// START-during-run and back-to-back sequences. Outputs sampled on negedge.
module tb_seq_mult_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] OP1;
  logic [7:0] OP2;
  logic [2:0] DESTADDR;
  logic [7:0] RESULT;
  logic [2:0] WRITEADDR;
  logic       WRITE;
  logic       BUSY;
  logic       OVF;

  int total = 0;
  int bad   = 0;

  seq_mult_unit #(.DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP1(OP1), .OP2(OP2),
    .DESTADDR(DESTADDR), .RESULT(RESULT), .WRITEADDR(WRITEADDR),
    .WRITE(WRITE), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] d;
    logic [7:0] er;
    logic       eo;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Start an operation and check the whole 9-edge latency window.
  // When disturb is set, START stays high and operands change during RUN/WB.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d,
                       input logic disturb, input logic [7:0] er, input logic eo,
                       input string tag);
    int busy_bad;
    int wr_bad;
    @(negedge CLK);
    START = 1'b1; OP1 = a; OP2 = b; DESTADDR = d;
    @(negedge CLK);
    START = disturb;
    OP1 = 8'h01; OP2 = 8'h01; DESTADDR = ~d;
    busy_bad = 0;
    wr_bad   = 0;
    for (int i = 0; i < 9; i++) begin
      if (BUSY !== 1'b1) busy_bad++;
      if (WRITE !== 1'b0) wr_bad++;
      @(negedge CLK);
    end
    check({tag, " busy_cycles_bad"}, 16'(busy_bad), 16'd0);
    check({tag, " early_write"}, 16'(wr_bad), 16'd0);
    START = 1'b0;
    check({tag, " write"}, 16'(WRITE), 16'd1);
    check({tag, " busy_at_write"}, 16'(BUSY), 16'd0);
    check({tag, " result"}, 16'(RESULT), 16'(er));
    check({tag, " ovf"}, 16'(OVF), 16'(eo));
    check({tag, " writeaddr"}, 16'(WRITEADDR), 16'(d));
    @(negedge CLK);
    check({tag, " write_one_cycle"}, 16'(WRITE), 16'd0);
    check({tag, " result_held"}, 16'(RESULT), 16'(er));
    check({tag, " idle_after"}, 16'(BUSY), 16'd0);
  endtask

  // Start 10x10 and pull reset so that it is sampled at edge n after the start edge.
  task automatic abort_at(input int n, input string tag);
    int writes;
    @(negedge CLK);
    START = 1'b1; OP1 = 8'd10; OP2 = 8'd10; DESTADDR = 3'd2;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 1; i < n; i++) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    check({tag, " write"}, 16'(WRITE), 16'd0);
    check({tag, " busy"}, 16'(BUSY), 16'd0);
    check({tag, " result"}, 16'(RESULT), 16'd0);
    check({tag, " ovf"}, 16'(OVF), 16'd0);
    check({tag, " writeaddr"}, 16'(WRITEADDR), 16'd0);
    writes = 0;
    for (int i = 0; i < 12; i++) begin
      if (WRITE === 1'b1) writes++;
      @(negedge CLK);
    end
    check({tag, " no_late_write"}, 16'(writes), 16'd0);
  endtask

  initial begin
    vec_t vecs[8];
    int   wr_cycle[$];

    vecs[0] = '{a: 8'd5,   b: 8'd6,   d: 3'd3, er: 8'd30,  eo: 1'b0};
    vecs[1] = '{a: 8'd20,  b: 8'd13,  d: 3'd1, er: 8'd4,   eo: 1'b1};
    vecs[2] = '{a: 8'd255, b: 8'd255, d: 3'd7, er: 8'd1,   eo: 1'b1};
    vecs[3] = '{a: 8'hFE,  b: 8'h03,  d: 3'd4, er: 8'hFA,  eo: 1'b1};
    vecs[4] = '{a: 8'd0,   b: 8'd200, d: 3'd5, er: 8'd0,   eo: 1'b0};
    vecs[5] = '{a: 8'd16,  b: 8'd16,  d: 3'd0, er: 8'd0,   eo: 1'b1};
    vecs[6] = '{a: 8'd15,  b: 8'd17,  d: 3'd6, er: 8'd255, eo: 1'b0};
    vecs[7] = '{a: 8'd128, b: 8'd1,   d: 3'd2, er: 8'd128, eo: 1'b0};

    // Reset with START high: reset wins, outputs cleared
    RESET = 1'b0; START = 1'b1; OP1 = 8'd9; OP2 = 8'd9; DESTADDR = 3'd5;
    repeat (3) @(negedge CLK);
    check("reset busy", 16'(BUSY), 16'd0);
    check("reset write", 16'(WRITE), 16'd0);
    check("reset result", 16'(RESULT), 16'd0);
    check("reset ovf", 16'(OVF), 16'd0);
    check("reset writeaddr", 16'(WRITEADDR), 16'd0);
    START = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check("post_reset idle", 16'(BUSY), 16'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].d, 1'b0, vecs[i].er, vecs[i].eo,
            $sformatf("vec%0d", i));
    end

    // START reasserted and operands changed while running: one write of 63
    do_op(8'd7, 8'd9, 3'd1, 1'b1, 8'd63, 1'b0, "restart_ignored");
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (WRITE === 1'b1 || BUSY === 1'b1) extra++;
        @(negedge CLK);
      end
      check("restart_ignored second_op", 16'(extra), 16'd0);
    end

    // Run a nonzero op so the abort checks see the reset clear RESULT
    do_op(8'd3, 8'd5, 3'd4, 1'b0, 8'd15, 1'b0, "pre_abort");
    abort_at(4, "abort_run");
    do_op(8'd3, 8'd4, 3'd3, 1'b0, 8'd12, 1'b0, "after_abort");
    abort_at(9, "abort_wb");
    do_op(8'd3, 8'd4, 3'd6, 1'b0, 8'd12, 1'b0, "after_wb_abort");

    // START held high: back-to-back operations with a 10-edge period
    @(negedge CLK);
    START = 1'b1; OP1 = 8'd2; OP2 = 8'd3; DESTADDR = 3'd6;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (WRITE === 1'b1) begin
        wr_cycle.push_back(k);
        check("b2b result", 16'(RESULT), 16'd6);
      end
    end
    START = 1'b0;
    check("b2b write_count", 16'(wr_cycle.size()), 16'd2);
    if (wr_cycle.size() >= 1) check("b2b first_latency", 16'(wr_cycle[0]), 16'd9);
    if (wr_cycle.size() >= 2) check("b2b period", 16'(wr_cycle[1] - wr_cycle[0]), 16'd10);
    repeat (12) @(negedge CLK);
    check("b2b drained", 16'(BUSY), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 SHALL have parameter: DATA_W, 8, operand/result width in bits; only 8 is supported.
REQ-002 SHALL have port: CLK  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: RESET  in  1  synchronous, active-low reset, sampled on CLK rising edge.
REQ-004 SHALL have port: START  in  1  request to multiply OP1 by OP2.
REQ-005 SHALL have port: OP1  in  8  multiplicand, driven from register file OUT1.
REQ-006 SHALL have port: OP2  in  8  multiplier, driven from register file OUT2.
REQ-007 SHALL have port: DESTADDR  in  3  destination register index for the result.
REQ-008 SHALL have port: RESULT  out  8  low byte of product, driven to register file IN.
REQ-009 SHALL have port: WRITEADDR  out  3  latched DESTADDR, driven to register file INADDRESS.
REQ-010 SHALL have port: WRITE  out  1  one-cycle write-enable to register file WRITE.
REQ-011 SHALL have port: BUSY  out  1  high while an operation is in progress; used to stall the PC.
REQ-012 SHALL have port: OVF  out  1  unsigned product exceeded 255.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, WB.
REQ-014 IDLE: START=1 at an edge SHALL latch OP1, OP2 and DESTADDR, clear the 16-bit accumulator and the bit counter, and go to RUN; START=0 SHALL stay in IDLE.
REQ-015 RUN: each edge SHALL process one multiplier bit, LSB first.
  - If the current bit is 1, SHALL add the multiplicand (shifted to the current bit position) to the accumulator.
  - SHALL increment the counter.
  - After the 8th RUN edge (counter 7 to 8), SHALL go to WB.
REQ-016 WB: SHALL drive WRITE=1 for exactly one cycle and return to IDLE at the next edge.
REQ-017 In WB, RESULT SHALL equal accumulator[7:0] and OVF SHALL equal the OR of accumulator[15:8].
REQ-018 Latency SHALL be fixed at 9 edges: START sampled at edge 0 gives WRITE high between edge 9 and edge 10, independent of operand values; there is no early termination.
REQ-019 BUSY SHALL be 1 in RUN and WB and 0 in IDLE; it SHALL be decoded from registered state only.
REQ-020 START SHALL be ignored in RUN and WB; a new operation needs START high in IDLE.
REQ-021 OP1, OP2 and DESTADDR changes after the latching edge SHALL NOT affect the in-flight result.
REQ-022 RESULT, OVF and WRITEADDR SHALL hold their last WB values until the next WB; WRITE SHALL be 0 outside WB.
REQ-023 Low-byte arithmetic SHALL be two's-complement-correct, i.e. identical for signed and unsigned operands; OVF is defined on the unsigned interpretation only.
REQ-024 All outputs SHALL be registered or decoded from registered state; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-025 RESET=0 at an edge SHALL force state IDLE and clear the counter, accumulator, RESULT, WRITEADDR, OVF and WRITE to 0.
REQ-026 Reset SHALL take priority over START at the same edge.
REQ-027 Reset in RUN or WB SHALL abort the operation with no WRITE pulse; if reset coincides with WB, WRITE SHALL be 0 in the following cycle.
REQ-028 After reset is released, the first START SHALL behave per REQ-014 with no residual state.

Verification
REQ-029 Bench SHALL cover: OP1=5, OP2=6, DESTADDR=3, START pulse -> BUSY for 9 cycles; in the 10th cycle WRITE=1, RESULT=30, WRITEADDR=3, OVF=0.
REQ-030 Bench SHALL cover: OP1=20, OP2=13 -> RESULT=4 (260 mod 256), OVF=1; OP1=255, OP2=255 -> RESULT=1, OVF=1.
REQ-031 Bench SHALL cover: OP1=0xFE (-2), OP2=0x03 -> RESULT=0xFA (-6), OVF=1.
REQ-032 Bench SHALL cover: OP1=7, OP2=9 started, then START reasserted with OP1=1, OP2=1 during RUN and OPs changed -> single WRITE with RESULT=63; no second WRITE.
REQ-033 Bench SHALL cover: OP1=10, OP2=10, RESET=0 at the 4th RUN edge -> no WRITE pulse, BUSY=0, RESULT=0, OVF=0; a subsequent 3x4 operation gives RESULT=12 with standard latency.
REQ-034 Bench SHALL cover: START held high continuously -> back-to-back operations, each WRITE separated by one IDLE cycle (10-edge period).
